// File: rtl/debounce_pkg.sv
// Shared types and constants for the multi-channel debouncer.
package debounce_pkg;

    // Per-channel FSM state encoding; bit 1 doubles as the debounced level.
    typedef enum logic [1:0] {
        ST_ZERO  = 2'b00,
        ST_WAIT1 = 2'b01,
        ST_ONE   = 2'b10,
        ST_WAIT0 = 2'b11
    } state_e;

    // Deepest synchronizer supported; larger requests are clamped to this.
    localparam int SYNC_MAX = 3;

    // Default hold counter width.
    localparam int CW_DEFAULT = 16;

    // Clamp a requested synchronizer depth into the supported 0..SYNC_MAX range.
    function automatic int sync_depth(input int req);
        int depth;
        if (req < 0) begin
            depth = 0;
        end else if (req > SYNC_MAX) begin
            depth = SYNC_MAX;
        end else begin
            depth = req;
        end
        return depth;
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debouncer channel: optional input synchronizer, 4-state hold FSM,
// down-counter and registered level / event outputs.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int CW   = CW_DEFAULT,
    parameter int SYNC = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          in,
    input  logic          en,
    input  logic [CW-1:0] rise_len,
    input  logic [CW-1:0] fall_len,
    output logic          db_level,
    output logic          rise_tick,
    output logic          fall_tick,
    output logic          glitch
);

    localparam int            SYNC_EFF = sync_depth(SYNC);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

    logic          s_in_s;
    state_e        state_r;
    state_e        state_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          db_level_r;
    logic          rise_tick_r;
    logic          fall_tick_r;
    logic          glitch_r;
    logic          rise_nxt_s;
    logic          fall_nxt_s;
    logic          glitch_nxt_s;

    generate
        if (SYNC_EFF == 0) begin : g_no_sync
            assign s_in_s = in;
        end else begin : g_sync
            logic [SYNC_EFF-1:0] sync_r;

            // Synchronizer chain; runs regardless of en so s_in stays current.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    sync_r <= {SYNC_EFF{1'b0}};
                end else begin
                    sync_r[0] <= in;
                    for (int i = 1; i < SYNC_EFF; i++) begin
                        sync_r[i] <= sync_r[i-1];
                    end
                end
            end

            assign s_in_s = sync_r[SYNC_EFF-1];
        end
    endgenerate

    // Next-state, counter and event decode; hold lengths are captured only on wait entry.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        rise_nxt_s   = 1'b0;
        fall_nxt_s   = 1'b0;
        glitch_nxt_s = 1'b0;
        if (en) begin
            case (state_r)
                ST_ZERO: begin
                    if (s_in_s) begin
                        if (rise_len == CNT_ZERO) begin
                            state_nxt_s = ST_ONE;
                            rise_nxt_s  = 1'b1;
                        end else begin
                            state_nxt_s = ST_WAIT1;
                            cnt_nxt_s   = rise_len;
                        end
                    end else begin
                        state_nxt_s = ST_ZERO;
                    end
                end
                ST_WAIT1: begin
                    if (s_in_s) begin
                        if (cnt_r <= CNT_ONE) begin
                            state_nxt_s = ST_ONE;
                            cnt_nxt_s   = CNT_ZERO;
                            rise_nxt_s  = 1'b1;
                        end else begin
                            cnt_nxt_s = cnt_r - CNT_ONE;
                        end
                    end else begin
                        state_nxt_s  = ST_ZERO;
                        cnt_nxt_s    = CNT_ZERO;
                        glitch_nxt_s = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (!s_in_s) begin
                        if (fall_len == CNT_ZERO) begin
                            state_nxt_s = ST_ZERO;
                            fall_nxt_s  = 1'b1;
                        end else begin
                            state_nxt_s = ST_WAIT0;
                            cnt_nxt_s   = fall_len;
                        end
                    end else begin
                        state_nxt_s = ST_ONE;
                    end
                end
                ST_WAIT0: begin
                    if (!s_in_s) begin
                        if (cnt_r <= CNT_ONE) begin
                            state_nxt_s = ST_ZERO;
                            cnt_nxt_s   = CNT_ZERO;
                            fall_nxt_s  = 1'b1;
                        end else begin
                            cnt_nxt_s = cnt_r - CNT_ONE;
                        end
                    end else begin
                        state_nxt_s  = ST_ONE;
                        cnt_nxt_s    = CNT_ZERO;
                        glitch_nxt_s = 1'b1;
                    end
                end
                default: begin
                    state_nxt_s = ST_ZERO;
                    cnt_nxt_s   = CNT_ZERO;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
            cnt_nxt_s   = cnt_r;
        end
    end

    // State, counter and registered outputs; level is decoded from the next state
    // so it lines up with the state register and the event pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= ST_ZERO;
            cnt_r       <= CNT_ZERO;
            db_level_r  <= 1'b0;
            rise_tick_r <= 1'b0;
            fall_tick_r <= 1'b0;
            glitch_r    <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            db_level_r  <= (state_nxt_s == ST_ONE) || (state_nxt_s == ST_WAIT0);
            rise_tick_r <= rise_nxt_s;
            fall_tick_r <= fall_nxt_s;
            glitch_r    <= glitch_nxt_s;
        end
    end

    assign db_level  = db_level_r;
    assign rise_tick = rise_tick_r;
    assign fall_tick = fall_tick_r;
    assign glitch    = glitch_r;

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel debouncer: CH independent debounce_chan instances sharing
// enable and rise/fall hold lengths.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int CH   = 8,
    parameter int CW   = CW_DEFAULT,
    parameter int SYNC = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [CH-1:0] in,
    input  logic          en,
    input  logic [CW-1:0] rise_len,
    input  logic [CW-1:0] fall_len,
    output logic [CH-1:0] db_level,
    output logic [CH-1:0] rise_tick,
    output logic [CH-1:0] fall_tick,
    output logic [CH-1:0] glitch
);

    generate
        for (genvar g = 0; g < CH; g++) begin : g_chan
            debounce_chan #(
                .CW   (CW),
                .SYNC (SYNC)
            ) u_chan (
                .clk       (clk),
                .rstn      (rstn),
                .in        (in[g]),
                .en        (en),
                .rise_len  (rise_len),
                .fall_len  (fall_len),
                .db_level  (db_level[g]),
                .rise_tick (rise_tick[g]),
                .fall_tick (fall_tick[g]),
                .glitch    (glitch[g])
            );
        end
    endgenerate

endmodule

// File: tb/tb_debounce_multi.sv
// Directed self-checking bench for debounce_multi (CH=4, CW=8, SYNC=2).
module tb_debounce_multi;

    logic       clk;
    logic       rstn;
    logic [3:0] in;
    logic       en;
    logic [7:0] rise_len;
    logic [7:0] fall_len;
    logic [3:0] db_level;
    logic [3:0] rise_tick;
    logic [3:0] fall_tick;
    logic [3:0] glitch;

    int errors = 0;
    int checks = 0;

    debounce_multi #(
        .CH   (4),
        .CW   (8),
        .SYNC (2)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in        (in),
        .en        (en),
        .rise_len  (rise_len),
        .fall_len  (fall_len),
        .db_level  (db_level),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick),
        .glitch    (glitch)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; in = 4'hF; en = 1'b1; rise_len = 8'd5; fall_len = 8'd2;
        #20;
        checks++; if (db_level  !== 4'h0) begin errors++; $display("FAIL reset_db: got %b want 0000", db_level); end
        checks++; if (rise_tick !== 4'h0) begin errors++; $display("FAIL reset_rise: got %b want 0000", rise_tick); end
        checks++; if (fall_tick !== 4'h0) begin errors++; $display("FAIL reset_fall: got %b want 0000", fall_tick); end
        checks++; if (glitch    !== 4'h0) begin errors++; $display("FAIL reset_glitch: got %b want 0000", glitch); end
        in = 4'h0;
        #2 rstn = 1'b1;
        for (int i = 0; i < 100; i++) begin
            clk_n(1);
            checks++;
            if ({db_level, rise_tick, fall_tick, glitch} !== 16'h0000) begin
                errors++;
                $display("FAIL idle_after_reset: cycle %0d got %h want 0000", i, {db_level, rise_tick, fall_tick, glitch});
            end
        end
    endtask

    task automatic test_clean_rise();
        rise_len = 8'd5;
        in = 4'b0001;
        clk_n(7);
        checks++; if (db_level  !== 4'b0000) begin errors++; $display("FAIL rise_early_db: got %b want 0000", db_level); end
        checks++; if (rise_tick !== 4'b0000) begin errors++; $display("FAIL rise_early_tick: got %b want 0000", rise_tick); end
        clk_n(1);
        checks++; if (db_level  !== 4'b0001) begin errors++; $display("FAIL rise_db: got %b want 0001", db_level); end
        checks++; if (rise_tick !== 4'b0001) begin errors++; $display("FAIL rise_tick: got %b want 0001", rise_tick); end
        clk_n(1);
        checks++; if (rise_tick !== 4'b0000) begin errors++; $display("FAIL rise_tick_width: got %b want 0000", rise_tick); end
        checks++; if (db_level  !== 4'b0001) begin errors++; $display("FAIL rise_db_hold: got %b want 0001", db_level); end
    endtask

    task automatic test_glitch();
        rise_len = 8'd5;
        in = 4'b0011;
        clk_n(4);
        in = 4'b0001;
        clk_n(2);
        checks++; if (glitch !== 4'b0000) begin errors++; $display("FAIL glitch_early: got %b want 0000", glitch); end
        clk_n(1);
        checks++; if (glitch    !== 4'b0010) begin errors++; $display("FAIL glitch_pulse: got %b want 0010", glitch); end
        checks++; if (db_level  !== 4'b0001) begin errors++; $display("FAIL glitch_db: got %b want 0001", db_level); end
        checks++; if (rise_tick !== 4'b0000) begin errors++; $display("FAIL glitch_no_rise: got %b want 0000", rise_tick); end
        clk_n(1);
        checks++; if (glitch    !== 4'b0000) begin errors++; $display("FAIL glitch_width: got %b want 0000", glitch); end
        checks++; if (rise_tick !== 4'b0000) begin errors++; $display("FAIL glitch_no_rise_late: got %b want 0000", rise_tick); end
    endtask

    task automatic test_fall_and_zero_rise();
        fall_len = 8'd2;
        in = 4'b0000;
        clk_n(4);
        checks++; if (db_level  !== 4'b0001) begin errors++; $display("FAIL fall_early_db: got %b want 0001", db_level); end
        checks++; if (fall_tick !== 4'b0000) begin errors++; $display("FAIL fall_early_tick: got %b want 0000", fall_tick); end
        clk_n(1);
        checks++; if (fall_tick !== 4'b0001) begin errors++; $display("FAIL fall_tick: got %b want 0001", fall_tick); end
        checks++; if (db_level  !== 4'b0000) begin errors++; $display("FAIL fall_db: got %b want 0000", db_level); end
        clk_n(1);
        checks++; if (fall_tick !== 4'b0000) begin errors++; $display("FAIL fall_tick_width: got %b want 0000", fall_tick); end
        rise_len = 8'd0;
        in = 4'b0001;
        clk_n(2);
        checks++; if (db_level  !== 4'b0000) begin errors++; $display("FAIL zrise_early_db: got %b want 0000", db_level); end
        clk_n(1);
        checks++; if (db_level  !== 4'b0001) begin errors++; $display("FAIL zrise_db: got %b want 0001", db_level); end
        checks++; if (rise_tick !== 4'b0001) begin errors++; $display("FAIL zrise_tick: got %b want 0001", rise_tick); end
        in = 4'b0000;
        clk_n(8);
        checks++; if (db_level  !== 4'b0000) begin errors++; $display("FAIL zrise_return_db: got %b want 0000", db_level); end
    endtask

    task automatic test_freeze_and_config();
        rise_len = 8'd5;
        in = 4'b0100;
        clk_n(4);
        en = 1'b0;
        clk_n(5);
        checks++; if (db_level !== 4'b0000) begin errors++; $display("FAIL freeze_mid_db: got %b want 0000", db_level); end
        clk_n(5);
        checks++; if ({rise_tick, glitch} !== 8'h00) begin errors++; $display("FAIL freeze_pulses: got %h want 00", {rise_tick, glitch}); end
        en = 1'b1;
        clk_n(3);
        checks++; if (db_level  !== 4'b0000) begin errors++; $display("FAIL resume_early_db: got %b want 0000", db_level); end
        clk_n(1);
        checks++; if (db_level  !== 4'b0100) begin errors++; $display("FAIL resume_db: got %b want 0100", db_level); end
        checks++; if (rise_tick !== 4'b0100) begin errors++; $display("FAIL resume_tick: got %b want 0100", rise_tick); end
        in = 4'b1100;
        clk_n(4);
        rise_len = 8'd50;
        clk_n(3);
        checks++; if (db_level  !== 4'b0100) begin errors++; $display("FAIL cfg_early_db: got %b want 0100", db_level); end
        clk_n(1);
        checks++; if (db_level  !== 4'b1100) begin errors++; $display("FAIL cfg_db: got %b want 1100", db_level); end
        checks++; if (rise_tick !== 4'b1000) begin errors++; $display("FAIL cfg_tick: got %b want 1000", rise_tick); end
        rise_len = 8'd5;
    endtask

    task automatic test_reset_mid();
        fall_len = 8'd20;
        in = 4'b0000;
        clk_n(5);
        checks++; if (db_level !== 4'b1100) begin errors++; $display("FAIL wait0_db: got %b want 1100", db_level); end
        #2 rstn = 1'b0;
        #1;
        checks++; if (db_level !== 4'b0000) begin errors++; $display("FAIL midrst_db: got %b want 0000", db_level); end
        checks++; if ({rise_tick, fall_tick, glitch} !== 12'h000) begin errors++; $display("FAIL midrst_pulses: got %h want 000", {rise_tick, fall_tick, glitch}); end
        #2 rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            clk_n(1);
            checks++;
            if ({db_level, rise_tick, fall_tick, glitch} !== 16'h0000) begin
                errors++;
                $display("FAIL after_midrst: cycle %0d got %h want 0000", i, {db_level, rise_tick, fall_tick, glitch});
            end
        end
    endtask

    task automatic test_simultaneous();
        rise_len = 8'd3;
        in = 4'hF;
        clk_n(5);
        checks++; if (rise_tick !== 4'h0) begin errors++; $display("FAIL simul_early_tick: got %b want 0000", rise_tick); end
        checks++; if (db_level  !== 4'h0) begin errors++; $display("FAIL simul_early_db: got %b want 0000", db_level); end
        clk_n(1);
        checks++; if (rise_tick !== 4'hF) begin errors++; $display("FAIL simul_tick: got %b want 1111", rise_tick); end
        checks++; if (db_level  !== 4'hF) begin errors++; $display("FAIL simul_db: got %b want 1111", db_level); end
        clk_n(1);
        checks++; if (rise_tick !== 4'h0) begin errors++; $display("FAIL simul_tick_width: got %b want 0000", rise_tick); end
        checks++; if (db_level  !== 4'hF) begin errors++; $display("FAIL simul_db_hold: got %b want 1111", db_level); end
    endtask

    initial begin
        test_reset();
        test_clean_rise();
        test_glitch();
        test_fall_and_zero_rise();
        test_freeze_and_config();
        test_reset_mid();
        test_simultaneous();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/debounce_multi.md
# debounce_multi

Multi-channel, runtime-configurable successor to the single-input debouncer. It conditions up to `CH` slow digital inputs: external TTL triggers, lock/unlock flags and comparator outputs from the lock-in/PID path. Each channel gets its own optional input synchronizer, asymmetric rise/fall hold times set by registers, and rise, fall and glitch event pulses. It sits between raw pins or comparator bits and the lock control logic, which consumes `db_level` and the tick pulses.

## Interface
- `CH`, 8: number of independent channels.
- `CW`, 16: hold counter width; maximum hold length is 2^CW-1 cycles.
- `SYNC`, 2: input synchronizer stages, 0..3; 0 means `in` is used directly.
- `clk` input, 1: system clock (125 MHz, 8 ns).
- `rstn` input, 1: asynchronous, active-low reset.
- `in` input, CH: raw inputs, asynchronous to `clk` when SYNC>0.
- `en` input, 1: global enable; 0 freezes all channel FSMs.
- `rise_len` input, CW: extra cycles `in` must stay high before `db_level` rises; shared by all channels.
- `fall_len` input, CW: extra cycles `in` must stay low before `db_level` falls; shared by all channels.
- `db_level` output, CH: debounced level per channel.
- `rise_tick` output, CH: 1-cycle pulse when `db_level` goes 0→1.
- `fall_tick` output, CH: 1-cycle pulse when `db_level` goes 1→0.
- `glitch` output, CH: 1-cycle pulse when a pending transition aborts.

## Operation
- Per channel: a SYNC-deep flop chain produces `s_in`. Each channel then runs a 4-state FSM (ZERO, WAIT1, ONE, WAIT0) plus a CW-bit down-counter `cnt`.
- ZERO:
  - `s_in`=1 and `rise_len`=0 → go to ONE.
  - `s_in`=1 and `rise_len`>0 → load `cnt`=`rise_len`, go to WAIT1.
- WAIT1:
  - `s_in`=1 and `cnt`=1 → go to ONE.
  - `s_in`=1 and `cnt`>1 → decrement `cnt`.
  - `s_in`=0 → go to ZERO and pulse `glitch`.
- ONE and WAIT0 mirror ZERO and WAIT1, using `fall_len` and the opposite input polarity.
- `rise_len`/`fall_len` are sampled only when a wait state is entered. Changing them mid-count does not affect the count in progress.
- `db_level`=1 in ONE and WAIT0, and 0 in ZERO and WAIT1. It is a registered output decoded from the state register.
- `rise_tick`, `fall_tick` and `glitch` are registered. Each asserts in the same cycle the new state becomes visible.
- `en`=0:
  - The synchronizer keeps running.
  - FSM and `cnt` hold their values.
  - All pulse outputs are 0 and `db_level` holds.
- Illegal or unused state → ZERO on the next clock.
- Channels are fully independent; simultaneous events on different channels are all reported in the same cycle.

## Timing
- Reset (`rstn`=0, asynchronous): all FSMs go to ZERO, `cnt`=0, sync flops=0, and all outputs=0. Reset during a wait state abandons the count with no `glitch` pulse.
- Input latency: `s_in` follows `in` after SYNC clocks.
- Rise latency: with `s_in` first high in cycle 0 (state ZERO) and held, `db_level` and `rise_tick` are high in cycle `rise_len`+1. This holds uniformly, including `rise_len`=0, which gives cycle 1. `rise_len`+1 consecutive high samples are required.
- Fall latency is symmetric, using `fall_len`.
- Glitch timing: `s_in` returning in cycle k of a wait gives a `glitch` pulse in cycle k+1, with `db_level` unchanged.
- A single-cycle input bounce while in ONE with `fall_len`>0 produces a `glitch` only; no tick is emitted.
- Throughput: a new transition can be accepted in the cycle after a tick.

## Structure
- `debounce_pkg`:
  - state enum (ZERO=2'b00, WAIT1=2'b01, ONE=2'b10, WAIT0=2'b11);
  - the `SYNC` range check constant;
  - the default `CW`.
- Sub-module `debounce_chan`: one synchronizer, FSM and counter, instantiated CH times via a generate loop.
- The top level only fans out `en`/`rise_len`/`fall_len` and concatenates the per-channel outputs.

## Test plan
Bench settings: CH=4, CW=8, SYNC=2.
- Reset: `rstn`=0 while `in`=4'hF → all outputs 0. Release `rstn` with `in`=0 → outputs stay 0 for 100 cycles.
- Clean rise: `rise_len`=5, `in[0]` steps high and holds → `db_level[0]` and a 1-cycle `rise_tick[0]` appear exactly 8 clocks after the edge (2 sync + 6); channels 1-3 stay at 0.
- Glitch: `rise_len`=5, `in[1]` high for 4 cycles then low → `db_level[1]` stays 0; `glitch[1]` pulses 7 clocks after the rising edge; no `rise_tick`.
- Asymmetric fall and zero-length rise: `fall_len`=2 → `fall_tick` 5 clocks after the falling edge. `rise_len`=0 → `db_level` rises 3 clocks after the edge.
- Freeze and config change: `en`=0 in WAIT1 for 10 cycles → no change; the count resumes on `en`=1. Writing `rise_len` from 5 to 50 mid-wait → completion still occurs at the 5-cycle count.
- Reset mid-operation and simultaneous events: `rstn` pulsed in WAIT0 → `db_level`=0 immediately, no pulses. All four channels rising together with `rise_len`=3 → `rise_tick`=4'hF in a single cycle.
